datamem_pipe: RTL

Parametrised, synchronous successor to the processor's data memory, for the MEM stage of the 64-bit MIPS pipeline.
- Single clock, valid/ready request port, registered read response.
- Byte-enable writes; optional two-word "wide" store sequenced over two cycles on a single-write-port array.
- Out-of-range flagging; reset-safe control.

---
 rtl/datamem_pkg.sv | 26 ++
 rtl/datamem_pipe_if.sv | 37 +++
 rtl/datamem_array.sv | 46 ++++
 rtl/datamem_pipe.sv | 133 +++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datamem_pkg
// Description : Shared types and default sizing for the MEM-stage data memory
//               (datamem_pipe and its storage array).
// Revision    : 1.0 - initial release
// ============================================================================
package datamem_pkg;

  // Control states: IDLE accepts requests, WR2 writes the second word of a
  // wide store.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WR2  = 1'b1
  } state_e;

  // Default geometry used when the block is instantiated without overrides.
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_ADDR_W = 64;

  localparam int IDX_W = $clog2(DEF_DEPTH);
  localparam int BE_W  = DEF_DATA_W / 8;

endpackage
`default_nettype wire

// File: rtl/datamem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : datamem_pipe_if
// Description : Request/response bundle of the data memory. The master drives
//               requests and observes the registered response; the slave is
//               the memory block.
// Revision    : 1.0 - initial release
// ============================================================================
interface datamem_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_re;
  logic                  req_we;
  logic                  req_wide;
  logic [DATA_W/8-1:0]   req_be;
  logic [2*DATA_W-1:0]   req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_re, req_we, req_wide, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_re, req_we, req_wide, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/datamem_array.sv
`default_nettype none
// ============================================================================
// Module      : datamem_array
// Description : DEPTH x DATA_W storage with one byte-enabled synchronous write
//               port and one synchronous read port. A read and a write to the
//               same word on the same edge return the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module datamem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input  wire logic                       clk,
  input  wire logic                       i_we,
  input  wire logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  wire logic [DATA_W-1:0]          i_wdata,
  input  wire logic [DATA_W/8-1:0]        i_be,
  input  wire logic                       i_re,
  input  wire logic [$clog2(DEPTH)-1:0]   i_raddr,
  output      logic [DATA_W-1:0]          o_rdata
);

  localparam int c_BE_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset; the read register only loads on a
  // read so it holds its value while a wide store finishes.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
    if (i_we) begin
      for (int k = 0; k < c_BE_W; k++) begin
        if (i_be[k]) begin
          r_mem[i_waddr][k*8 +: 8] <= i_wdata[k*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/datamem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : datamem_pipe
// Description : Synchronous MEM-stage data memory with valid/ready requests,
//               byte-enabled narrow and two-word wide stores, registered
//               one-cycle response pulses and out-of-range flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module datamem_pipe
  import datamem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input wire logic        clk,
  input wire logic        rst_n,
  datamem_pipe_if.slave   bus
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_BE_W  = DATA_W / 8;

  localparam logic [0:0] c_S_IDLE = IDLE;
  localparam logic [0:0] c_S_WR2  = WR2;

  logic [0:0]          r_state;
  logic [c_IDX_W-1:0]  r_idx2;
  logic [DATA_W-1:0]   r_hi;
  logic [c_BE_W-1:0]   r_be;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic                r_rd_sel;

  logic                w_accept;
  logic                w_oor;
  logic                w_wide_go;
  logic                w_re;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_we;
  logic [c_IDX_W-1:0]  w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [c_BE_W-1:0]   w_wbe;
  logic [DATA_W-1:0]   w_arr_rdata;

  // DEPTH is a power of two, so any set bit above the index is out of range.
  generate
    if (ADDR_W > c_IDX_W) begin : g_range_chk
      assign w_oor = |bus.req_addr[ADDR_W-1:c_IDX_W];
    end else begin : g_no_range_chk
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_idx         = bus.req_addr[c_IDX_W-1:0];
  assign bus.req_ready = (r_state == c_S_IDLE);
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_wide_go     = w_accept & bus.req_we & bus.req_wide & ~w_oor;
  assign w_re          = w_accept & bus.req_re & ~w_oor;

  // Single write port: the request owns it in IDLE, the latched high word in WR2.
  always_comb begin
    w_we    = w_accept & bus.req_we & ~w_oor;
    w_waddr = w_idx;
    w_wdata = bus.req_wdata[DATA_W-1:0];
    w_wbe   = bus.req_be;
    if (r_state == c_S_WR2) begin
      w_we    = 1'b1;
      w_waddr = r_idx2;
      w_wdata = r_hi;
      w_wbe   = r_be;
    end
  end

  // Control FSM plus the second-word latch of a wide store (index wraps mod DEPTH).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_idx2  <= '0;
      r_hi    <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_wide_go) begin
            r_state <= c_S_WR2;
            r_idx2  <= w_idx + 1'b1;
            r_hi    <= bus.req_wdata[2*DATA_W-1:DATA_W];
            r_be    <= bus.req_be;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  // Response pulse: one cycle after accept, or after the WR2 cycle for wide stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_sel    <= 1'b0;
    end else begin
      r_rsp_valid <= (w_accept & ~w_wide_go) | (r_state == c_S_WR2);
      r_rsp_err   <= w_accept & w_oor;
      if (w_accept) begin
        r_rd_sel <= w_re;
      end else if (r_state != c_S_WR2) begin
        r_rd_sel <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rd_sel ? w_arr_rdata : '0;

  datamem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_be    (w_wbe),
    .i_re    (w_re),
    .i_raddr (w_idx),
    .o_rdata (w_arr_rdata)
  );

endmodule
`default_nettype wire
